// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: parity modes, FSM states, sizing helper.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StData   = 2'd1,
    StParity = 2'd2,
    StStop   = 2'd3
  } rx_state_e;

  // Bits needed for a counter that holds 0..max_val.
  function automatic int unsigned width_for(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// Show-ahead synchronous FIFO holding received words; head entry is always on rdata.
module uart_rx_sync_fifo #(
  parameter int unsigned Width = 10,
  parameter int unsigned Depth = 4
) (
  input  logic                    clock_115200hz,
  input  logic                    reset,
  input  logic                    push,
  input  logic [Width-1:0]        wdata,
  input  logic                    pop,
  output logic [Width-1:0]        rdata,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(Depth):0]  level
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] LevelFull = (PtrW + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    level_q;
  logic             do_push, do_pop;

  assign full    = (level_q == LevelFull);
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  // Masked while empty so the output is deterministic after reset.
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

  // Storage array; contents are only meaningful below the level count, so no reset.
  always_ff @(posedge clock_115200hz) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Pointers wrap naturally since Depth is a power of two.
  always_ff @(posedge clock_115200hz or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   level_q <= level_q + (PtrW + 1)'(1);
        2'b01:   level_q <= level_q - (PtrW + 1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver sampling once per bit clock, feeding a show-ahead FIFO with per-word
// error flags; cts throttles the host from FIFO fill level.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned PARITY        = 0,
  parameter int unsigned STOP_BITS     = 1,
  parameter int unsigned INVERT_RX     = 1,
  parameter int unsigned GUARD_BITS    = 4,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned CTS_THRESHOLD = FIFO_DEPTH - 1
) (
  input  logic                                clock_115200hz,
  input  logic                                reset,
  input  logic                                rx,
  input  logic                                rts,
  output logic                                cts,
  output logic                                receiving,
  output logic [DATA_BITS-1:0]                rx_data,
  output logic                                rx_frame_err,
  output logic                                rx_parity_err,
  output logic                                rx_valid,
  input  logic                                rx_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_level,
  output logic                                overrun
);

  localparam int unsigned CntW   = width_for(DATA_BITS - 1);
  localparam int unsigned LevelW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned WordW  = DATA_BITS + 2;

  localparam logic [CntW-1:0]   LastData = CntW'(DATA_BITS - 1);
  localparam logic              LastStop = 1'(STOP_BITS - 1);
  localparam logic [3:0]        GuardMax = 4'(GUARD_BITS);
  localparam logic [LevelW-1:0] CtsThr   = LevelW'(CTS_THRESHOLD);

  rx_state_e            state_q, state_d;
  logic [CntW-1:0]      bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 par_q, par_d;
  logic                 par_err_q, par_err_d;
  logic                 frame_err_q, frame_err_d;
  logic [3:0]           guard_q, guard_d;
  logic                 overrun_q, overrun_d;

  logic                 line;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [WordW-1:0]     fifo_rdata;

  // Line is assumed bit-aligned to the clock; one sample per bit period.
  assign line = (INVERT_RX != 0) ? ~rx : rx;

  // Frame assembly: guard timing in idle, shift data LSB first, check parity and stop bits.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    stop_cnt_d  = stop_cnt_q;
    data_d      = data_q;
    par_d       = par_q;
    par_err_d   = par_err_q;
    frame_err_d = frame_err_q;
    guard_d     = guard_q;
    push        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (guard_q != GuardMax) begin
          guard_d = guard_q + 4'd1;
        end else if (!line) begin
          state_d     = StData;
          bit_cnt_d   = '0;
          par_d       = 1'b0;
          par_err_d   = 1'b0;
          frame_err_d = 1'b0;
        end
      end
      StData: begin
        data_d = {line, data_q[DATA_BITS-1:1]};
        par_d  = par_q ^ line;
        if (bit_cnt_q == LastData) begin
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          state_d    = (PARITY != PARITY_NONE) ? StParity : StStop;
        end else begin
          bit_cnt_d = bit_cnt_q + CntW'(1);
        end
      end
      StParity: begin
        // Even: data^parity must be 0; odd: must be 1.
        par_err_d  = (PARITY == PARITY_EVEN) ? (par_q ^ line) : ~(par_q ^ line);
        stop_cnt_d = 1'b0;
        state_d    = StStop;
      end
      StStop: begin
        frame_err_d = frame_err_q | ~line;
        if (stop_cnt_q == LastStop) begin
          push    = 1'b1;
          guard_d = '0;
          state_d = StIdle;
        end else begin
          stop_cnt_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Receiver state; reset leaves the guard expired so a start bit is taken immediately.
  always_ff @(posedge clock_115200hz or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      stop_cnt_q  <= 1'b0;
      data_q      <= '0;
      par_q       <= 1'b0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      guard_q     <= GuardMax;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      stop_cnt_q  <= stop_cnt_d;
      data_q      <= data_d;
      par_q       <= par_d;
      par_err_q   <= par_err_d;
      frame_err_q <= frame_err_d;
      guard_q     <= guard_d;
      overrun_q   <= overrun_d;
    end
  end

  assign pop       = rx_valid && rx_ready;
  // Dropped word: push into a full FIFO that is not being drained this cycle.
  assign overrun_d = push && fifo_full && !pop;

  uart_rx_sync_fifo #(
    .Width (WordW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clock_115200hz (clock_115200hz),
    .reset          (reset),
    .push           (push),
    .wdata          ({par_err_q, frame_err_d, data_d}),
    .pop            (pop),
    .rdata          (fifo_rdata),
    .full           (fifo_full),
    .empty          (fifo_empty),
    .level          (fifo_level)
  );

  assign receiving     = (state_q != StIdle);
  assign rx_valid      = !fifo_empty;
  assign rx_data       = fifo_rdata[DATA_BITS-1:0];
  assign rx_frame_err  = fifo_rdata[DATA_BITS];
  assign rx_parity_err = (PARITY != PARITY_NONE) && fifo_rdata[DATA_BITS+1];
  assign overrun       = overrun_q;
  assign cts           = rts && (fifo_level < CtsThr);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench: instance a uses defaults (8N1, guard 4, depth 4); instance b uses even
// parity and two stop bits. Both invert rx, so line idle (L=1) means rx=0.
module tb_uart_rx_fifo;

  logic       clock_115200hz = 1'b0;
  logic       reset;

  logic       rx_a, rts_a, cts_a, receiving_a, fe_a, pe_a, valid_a, ready_a, overrun_a;
  logic [7:0] data_a;
  logic [2:0] level_a;

  logic       rx_b, rts_b, cts_b, receiving_b, fe_b, pe_b, valid_b, ready_b, overrun_b;
  logic [7:0] data_b;
  logic [2:0] level_b;

  int checks   = 0;
  int failures = 0;

  initial forever #5 clock_115200hz = ~clock_115200hz;

  uart_rx_fifo dut_a (
    .clock_115200hz (clock_115200hz),
    .reset          (reset),
    .rx             (rx_a),
    .rts            (rts_a),
    .cts            (cts_a),
    .receiving      (receiving_a),
    .rx_data        (data_a),
    .rx_frame_err   (fe_a),
    .rx_parity_err  (pe_a),
    .rx_valid       (valid_a),
    .rx_ready       (ready_a),
    .fifo_level     (level_a),
    .overrun        (overrun_a)
  );

  uart_rx_fifo #(
    .PARITY    (2),
    .STOP_BITS (2)
  ) dut_b (
    .clock_115200hz (clock_115200hz),
    .reset          (reset),
    .rx             (rx_b),
    .rts            (rts_b),
    .cts            (cts_b),
    .receiving      (receiving_b),
    .rx_data        (data_b),
    .rx_frame_err   (fe_b),
    .rx_parity_err  (pe_b),
    .rx_valid       (valid_b),
    .rx_ready       (ready_b),
    .fifo_level     (level_b),
    .overrun        (overrun_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next active edge; outputs are settled and inputs may be driven.
  task automatic step();
    @(posedge clock_115200hz);
    #1;
  endtask

  task automatic idle(input int n);
    rx_a = 1'b0;
    rx_b = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  // 8N1 frame on instance a; returns just after the push edge.
  task automatic send_a(input logic [7:0] d);
    rx_a = 1'b1;  // L=0 start bit
    step();
    check("a_receiving_after_start", 32'(receiving_a), 32'd1);
    for (int i = 0; i < 8; i++) begin
      rx_a = ~d[i];
      step();
    end
    rx_a = 1'b0;  // stop bit L=1
    step();
  endtask

  // 8E2 frame on instance b with explicit parity and stop line levels.
  task automatic send_b(input logic [7:0] d, input logic p, input logic s1, input logic s2);
    rx_b = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      rx_b = ~d[i];
      step();
    end
    rx_b = ~p;
    step();
    rx_b = ~s1;
    step();
    rx_b = ~s2;
    step();
    rx_b = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    rx_a    = 1'b0;
    rx_b    = 1'b0;
    rts_a   = 1'b1;
    rts_b   = 1'b1;
    ready_a = 1'b1;
    ready_b = 1'b1;
    #12;
    check("rst_receiving", 32'(receiving_a), 32'd0);
    check("rst_valid", 32'(valid_a), 32'd0);
    check("rst_level", 32'(level_a), 32'd0);
    check("rst_overrun", 32'(overrun_a), 32'd0);
    check("rst_data", 32'(data_a), 32'd0);
    check("rst_ferr", 32'(fe_a), 32'd0);
    check("rst_perr", 32'(pe_a), 32'd0);
    check("rst_cts", 32'(cts_a), 32'd1);
    step();
    reset = 1'b0;

    // First frame right after reset: start accepted on the first edge.
    send_a(8'hA5);
    check("a5_valid", 32'(valid_a), 32'd1);
    check("a5_data", 32'(data_a), 32'hA5);
    check("a5_ferr", 32'(fe_a), 32'd0);
    check("a5_perr", 32'(pe_a), 32'd0);
    check("a5_receiving_done", 32'(receiving_a), 32'd0);
    step();
    check("a5_valid_one_cycle", 32'(valid_a), 32'd0);
    idle(5);

    // Guard: start at t+N+3 ignored, start at t+N+5 accepted.
    send_a(8'h11);
    check("g1_data", 32'(data_a), 32'h11);
    step();
    step();
    rx_a = 1'b1;
    step();
    check("guard_start_ignored", 32'(receiving_a), 32'd0);
    rx_a = 1'b0;
    step();
    send_a(8'h22);
    check("guard_next_valid", 32'(valid_a), 32'd1);
    check("guard_next_data", 32'(data_a), 32'h22);
    idle(5);

    // Even parity and stop-bit checks on instance b.
    send_b(8'h03, 1'b0, 1'b1, 1'b1);
    check("par_ok_valid", 32'(valid_b), 32'd1);
    check("par_ok_data", 32'(data_b), 32'h03);
    check("par_ok_perr", 32'(pe_b), 32'd0);
    check("par_ok_ferr", 32'(fe_b), 32'd0);
    idle(5);
    send_b(8'h03, 1'b1, 1'b1, 1'b1);
    check("par_bad_valid", 32'(valid_b), 32'd1);
    check("par_bad_data", 32'(data_b), 32'h03);
    check("par_bad_perr", 32'(pe_b), 32'd1);
    idle(5);
    send_b(8'h07, 1'b1, 1'b1, 1'b0);
    check("stop2_data", 32'(data_b), 32'h07);
    check("stop2_perr", 32'(pe_b), 32'd0);
    check("stop2_ferr", 32'(fe_b), 32'd1);
    idle(5);
    send_b(8'h03, 1'b0, 1'b0, 1'b1);
    check("stop1_ferr", 32'(fe_b), 32'd1);
    idle(5);

    // Fill, throttle and overrun on instance a.
    ready_a = 1'b0;
    send_a(8'h01);
    check("fill1_level", 32'(level_a), 32'd1);
    check("fill1_cts", 32'(cts_a), 32'd1);
    rts_a = 1'b0;
    #1;
    check("fill1_cts_no_rts", 32'(cts_a), 32'd0);
    rts_a = 1'b1;
    idle(5);
    send_a(8'h02);
    check("fill2_level", 32'(level_a), 32'd2);
    check("fill2_cts", 32'(cts_a), 32'd1);
    idle(5);
    send_a(8'h03);
    check("fill3_level", 32'(level_a), 32'd3);
    check("fill3_cts", 32'(cts_a), 32'd0);
    check("fill3_head", 32'(data_a), 32'h01);
    idle(5);
    send_a(8'h04);
    check("fill4_level", 32'(level_a), 32'd4);
    check("fill4_overrun", 32'(overrun_a), 32'd0);
    idle(5);
    send_a(8'h05);
    check("fill5_overrun", 32'(overrun_a), 32'd1);
    check("fill5_level", 32'(level_a), 32'd4);
    step();
    check("overrun_pulse_end", 32'(overrun_a), 32'd0);
    ready_a = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("drain_valid", 32'(valid_a), 32'd1);
      check("drain_data", 32'(data_a), 32'(i));
      step();
    end
    check("drain_empty", 32'(valid_a), 32'd0);
    check("drain_level", 32'(level_a), 32'd0);
    idle(5);

    // Reset mid-frame with one word queued.
    ready_a = 1'b0;
    send_a(8'h77);
    check("pre_rst_level", 32'(level_a), 32'd1);
    idle(5);
    rx_a = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      rx_a = ~i[0];
      step();
    end
    rx_a  = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_receiving", 32'(receiving_a), 32'd0);
    check("midrst_level", 32'(level_a), 32'd0);
    check("midrst_valid", 32'(valid_a), 32'd0);
    check("midrst_data", 32'(data_a), 32'd0);
    step();
    reset = 1'b0;
    send_a(8'h5A);
    check("postrst_level", 32'(level_a), 32'd1);
    check("postrst_data", 32'(data_a), 32'h5A);
    check("postrst_ferr", 32'(fe_a), 32'd0);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with a receive FIFO, the next-generation receive path for the LED actor's host link. It samples the line once per clock at the bit rate, assembles frames of configurable data width with optional parity and one or two stop bits, and flags framing and parity errors per word. Received words are queued in a small show-ahead FIFO drained by a valid/ready handshake. CTS is derived from FIFO fill level, so the host is throttled before data is lost.

## Interface
- DATA_BITS, 8: data bits per frame, legal 5..9, LSB first.
- PARITY, 0: 0 none, 1 odd, 2 even.
- STOP_BITS, 1: 1 or 2.
- INVERT_RX, 1: 1 means line level = ~rx (idle rx=0); 0 means line level = rx.
- GUARD_BITS, 4: idle clocks after a frame before a new start bit is accepted, legal 0..15.
- FIFO_DEPTH, 4: entries, power of two, at least 2.
- CTS_THRESHOLD, FIFO_DEPTH-1: cts deasserts when fifo_level >= this.
- clock_115200hz  in  1  bit-rate clock, one sample per bit.
- reset  in  1  reset, asynchronous, active-high.
- rx  in  1  serial input, asynchronous.
- rts  in  1  host request to send.
- cts  out  1  clear to send.
- receiving  out  1  frame in progress, start bit seen.
- rx_data  out  DATA_BITS  head-of-FIFO data.
- rx_frame_err  out  1  head word had a stop bit sampled 0.
- rx_parity_err  out  1  head word failed parity; always 0 when PARITY=0.
- rx_valid  out  1  FIFO non-empty.
- rx_ready  in  1  consumer accepts head word.
- fifo_level  out  $clog2(FIFO_DEPTH+1)  entries held.
- overrun  out  1  one-cycle pulse when a completed word is dropped.

## Operation
- Line level L = INVERT_RX ? ~rx : rx. Idle is L=1; the start bit is L=0.
- FSM states:
  - IDLE: guard counter runs up to GUARD_BITS. When the guard has expired and L=0, go to DATA and set receiving=1.
  - DATA: sample L into bit index 0..DATA_BITS-1, one bit per clock. After the last bit, go to PARITY if PARITY!=0, else to STOP.
  - PARITY: sample one bit and check it. Odd: XOR of data and parity bit = 1. Even: XOR = 0.
  - STOP: sample STOP_BITS bits. Any 0 sets the frame error. On the last stop sample, push {parity_err, frame_err, data}, clear receiving, zero the guard counter, and return to IDLE.
- Words with errors are still pushed, with their flags.
- FIFO is show-ahead. rx_data and the flags are valid whenever rx_valid=1. A pop occurs on a clock edge with rx_valid && rx_ready.
- Push with FIFO full and no pop in the same cycle: the word is dropped, FIFO contents are unchanged, and overrun=1 for one cycle.
- Push and pop in the same cycle when full: both succeed, and the level is unchanged.
- Push and pop in the same cycle when empty: not possible, since rx_valid=0 while empty.
- cts = rts && (fifo_level < CTS_THRESHOLD), combinational.
- Reset mid-frame: the frame is discarded, the FIFO is emptied, and the FSM returns to IDLE with the guard expired.

## Timing
- Reset values:
  - receiving=0, rx_valid=0, fifo_level=0, overrun=0.
  - rx_data=0, rx_frame_err=0, rx_parity_err=0.
  - Guard counter expired, so a start bit is accepted on the first clock after reset.
- Start bit sampled at edge t. Data bit i is sampled at t+1+i.
- Frame length after the start bit: N = DATA_BITS + (PARITY!=0) + STOP_BITS clocks. The push occurs at edge t+N.
- rx_valid rises after edge t+N. receiving falls after edge t+N.
- The earliest accepted next start bit is at edge t+N+GUARD_BITS+1.
- Pop to next-word visibility: the next entry appears after the same edge.

## Structure
- Shared package uart_pkg:
  - Parity constants PARITY_NONE=0, PARITY_ODD=1, PARITY_EVEN=2.
  - FSM state encodings IDLE/DATA/PARITY/STOP.
  - Function width_for(depth) for counter sizing.
- One sub-module: uart_rx_sync_fifo, parametrised by width (DATA_BITS+2) and depth, with push/pop/full/empty/level.
- Pointers wrap modulo FIFO_DEPTH. The level counter is one bit wider than the pointers.
- The FSM, shift register, guard counter and parity accumulator live in uart_rx_fifo.

## Test plan
- Defaults, INVERT_RX=1, rx_ready=1: send 0xA5 → rx_data=0xA5, rx_valid high for one cycle at t+9, both error flags 0.
- PARITY=2, 8 data bits: send 0x03 with parity bit 0 → parity_err=0. Send 0x03 with parity bit 1 → parity_err=1, word still stored.
- STOP_BITS=2: second stop bit sampled 0 → rx_frame_err=1 on that word.
- FIFO_DEPTH=4, rx_ready=0: send 5 frames (0x01..0x05).
  - After frame 3: cts=0 while rts=1.
  - After frame 5: overrun pulses once.
  - Then drain with rx_ready=1: output is 0x01..0x04 in order.
- Back-to-back start bits with GUARD_BITS=4: a start at t+N+3 is ignored, a start at t+N+5 is accepted.
- Reset asserted at data bit 4 mid-frame: no push, fifo_level=0. A frame sent immediately after reset is received correctly.
